// File: rtl/div_issue_queue_pkg.sv
// Shared types and helpers for the divide issue queue: dispatch/issue uop layouts,
// branch-bus field offsets, divide opcodes and the wrap-around sequence-number compare.
package div_issue_queue_pkg;

    localparam int unsigned DIV_LATENCY  = 34;
    localparam int unsigned BR_TAKEN_BIT = 51;
    localparam int unsigned BR_SQN_LSB   = 13;

    localparam logic [5:0] OP_DIV  = 6'h0c;
    localparam logic [5:0] OP_DIVU = 6'h0d;
    localparam logic [5:0] OP_REM  = 6'h0e;
    localparam logic [5:0] OP_REMU = 6'h0f;

    typedef struct packed {
        logic [31:0] srcA;
        logic [31:0] srcB;
        logic [5:0]  tagA;
        logic [5:0]  tagB;
        logic        availA;
        logic        availB;
        logic [5:0]  opcode;
        logic [5:0]  tagDst;
        logic [4:0]  nmDst;
        logic [5:0]  sqN;
        logic [31:0] pc;
    } DIV_DISP_UOP_T;

    typedef struct packed {
        logic [31:0] srcA;     // 170:139
        logic [31:0] srcB;     // 138:107
        logic [31:0] pc;       // 106:75
        logic [31:0] rsvd_hi;  // 74:43
        logic [5:0]  opcode;   // 42:37
        logic [5:0]  tagDst;   // 36:31
        logic [4:0]  nmDst;    // 30:26
        logic [5:0]  sqN;      // 25:20
        logic [18:0] rsvd_lo;  // 19:1
        logic        valid;    // 0
    } DIV_ISSUE_UOP_T;

    // a is older than b when the 6-bit difference is negative.
    function automatic logic sqn_older(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] d;
        d = a - b;
        return d[5];
    endfunction

    function automatic logic sqn_younger(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] d;
        d = a - b;
        return (d != 6'd0) && !d[5];
    endfunction

endpackage

// File: rtl/div_iq_select.sv
// Combinational oldest-ready picker: grants the valid, ready slot whose sqN is oldest.
module div_iq_select
    import div_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]      valid_i,
    input  logic [DEPTH-1:0]      ready_i,
    input  logic [DEPTH-1:0][5:0] sqn_i,
    output logic [DEPTH-1:0]      grant_o
);

    logic [DEPTH-1:0] cand;

    always_comb begin
        cand    = valid_i & ready_i;
        grant_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_o[i] = cand[i];
            for (int j = 0; j < DEPTH; j++) begin
                // An older rival, or an equal sqN in a lower slot, blocks slot i.
                if (j != i && cand[j] &&
                    (sqn_older(sqn_i[j], sqn_i[i]) || (j < i && sqn_i[j] == sqn_i[i]))) begin
                    grant_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/div_issue_queue.sv
// Divide issue queue: buffers dispatched divide uops, wakes operands from the result buses,
// issues the oldest ready uop spaced by the divider latency, and squashes on mispredict.
module div_issue_queue
    import div_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned NUM_WB      = 3,
    parameter int unsigned DIV_LATENCY = div_issue_queue_pkg::DIV_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IN_enqValid,
    input  DIV_DISP_UOP_T        IN_enqUop,
    output logic                 OUT_enqReady,
    input  logic [NUM_WB-1:0]    IN_wbValid,
    input  logic [NUM_WB*6-1:0]  IN_wbTag,
    input  logic [NUM_WB*32-1:0] IN_wbResult,
    input  logic [51:0]          IN_branch,
    input  logic                 IN_divBusy,
    output logic [170:0]         OUT_uop
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);

    DIV_DISP_UOP_T    entries_q [DEPTH];
    DIV_DISP_UOP_T    entries_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             enq_ready_q, enq_ready_d;
    DIV_ISSUE_UOP_T   out_q, out_d;
    logic [CNT_W-1:0] cooldown_q, cooldown_d;
    logic             inflight_valid_q, inflight_valid_d;
    logic [5:0]       inflight_sqn_q, inflight_sqn_d;

    logic                  br_kill;
    logic [5:0]            br_sqn;
    logic [DEPTH-1:0]      ready;
    logic [DEPTH-1:0]      grant;
    logic [DEPTH-1:0][5:0] sqn;
    logic                  issue;
    DIV_DISP_UOP_T         issue_uop;
    logic                  enq_found;
    logic                  enq_fire;
    logic [IDX_W-1:0]      enq_idx;

    assign br_kill = IN_branch[BR_TAKEN_BIT];
    assign br_sqn  = IN_branch[BR_SQN_LSB +: 6];

    // Scanning buses from high to low lets the lowest matching bus win.
    function automatic DIV_DISP_UOP_T wakeup(input DIV_DISP_UOP_T u);
        DIV_DISP_UOP_T w;
        w = u;
        for (int i = NUM_WB - 1; i >= 0; i--) begin
            if (IN_wbValid[i]) begin
                if (!u.availA && IN_wbTag[i*6 +: 6] == u.tagA) begin
                    w.availA = 1'b1;
                    w.srcA   = IN_wbResult[i*32 +: 32];
                end
                if (!u.availB && IN_wbTag[i*6 +: 6] == u.tagB) begin
                    w.availB = 1'b1;
                    w.srcB   = IN_wbResult[i*32 +: 32];
                end
            end
        end
        return w;
    endfunction

    always_comb begin
        issue_uop = entries_q[0];
        for (int e = 0; e < DEPTH; e++) begin
            ready[e] = entries_q[e].availA & entries_q[e].availB;
            sqn[e]   = entries_q[e].sqN;
            if (grant[e]) begin
                issue_uop = entries_q[e];
            end
        end
    end

    div_iq_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .valid_i (valid_q),
        .ready_i (ready),
        .sqn_i   (sqn),
        .grant_o (grant)
    );

    always_comb begin
        valid_d          = valid_q;
        out_d            = '0;
        cooldown_d       = cooldown_q;
        inflight_valid_d = inflight_valid_q;
        inflight_sqn_d   = inflight_sqn_q;
        enq_found        = 1'b0;
        enq_idx          = '0;

        for (int e = 0; e < DEPTH; e++) begin
            entries_d[e] = wakeup(entries_q[e]);
        end

        if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - CNT_W'(1);
        end

        issue = !IN_divBusy && (cooldown_q == '0) && !br_kill && (|grant);
        if (issue) begin
            valid_d          = valid_q & ~grant;
            out_d.valid      = 1'b1;
            out_d.srcA       = issue_uop.srcA;
            out_d.srcB       = issue_uop.srcB;
            out_d.pc         = issue_uop.pc;
            out_d.opcode     = issue_uop.opcode;
            out_d.tagDst     = issue_uop.tagDst;
            out_d.nmDst      = issue_uop.nmDst;
            out_d.sqN        = issue_uop.sqN;
            cooldown_d       = CNT_W'(DIV_LATENCY - 1);
            inflight_valid_d = 1'b1;
            inflight_sqn_d   = issue_uop.sqN;
        end

        if (br_kill) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (sqn_younger(entries_q[e].sqN, br_sqn)) begin
                    valid_d[e] = 1'b0;
                end
            end
            // A squashed in-flight divide no longer needs its spacing window.
            if (inflight_valid_q && sqn_younger(inflight_sqn_q, br_sqn)) begin
                cooldown_d       = '0;
                inflight_valid_d = 1'b0;
            end
        end

        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (!valid_q[e]) begin
                enq_found = 1'b1;
                enq_idx   = IDX_W'(e);
            end
        end
        enq_fire = IN_enqValid && enq_ready_q && enq_found &&
                   !(br_kill && sqn_younger(IN_enqUop.sqN, br_sqn));
        if (enq_fire) begin
            entries_d[enq_idx] = wakeup(IN_enqUop);
            valid_d[enq_idx]   = 1'b1;
        end

        enq_ready_d = ~(&valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q          <= '0;
            enq_ready_q      <= 1'b1;
            out_q            <= '0;
            cooldown_q       <= '0;
            inflight_valid_q <= 1'b0;
            inflight_sqn_q   <= '0;
        end else begin
            valid_q          <= valid_d;
            enq_ready_q      <= enq_ready_d;
            out_q            <= out_d;
            cooldown_q       <= cooldown_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_sqn_q   <= inflight_sqn_d;
        end
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign OUT_uop      = out_q;
    assign OUT_enqReady = enq_ready_q;

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: directed vector table, hand-written corner sequences and a
// randomized run, all checked cycle by cycle against a queue-based reference model.
module tb_div_issue_queue;
    import div_issue_queue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int NUM_WB = 3;
    localparam int LAT    = DIV_LATENCY;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enq_valid;
    DIV_DISP_UOP_T        enq_uop;
    logic                 enq_ready;
    logic [NUM_WB-1:0]    wb_valid;
    logic [NUM_WB*6-1:0]  wb_tag;
    logic [NUM_WB*32-1:0] wb_result;
    logic [51:0]          branch;
    logic                 div_busy;
    logic [170:0]         out_uop;

    always #5 clk = ~clk;

    div_issue_queue #(
        .DEPTH       (DEPTH),
        .NUM_WB      (NUM_WB),
        .DIV_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_enqValid  (enq_valid),
        .IN_enqUop    (enq_uop),
        .OUT_enqReady (enq_ready),
        .IN_wbValid   (wb_valid),
        .IN_wbTag     (wb_tag),
        .IN_wbResult  (wb_result),
        .IN_branch    (branch),
        .IN_divBusy   (div_busy),
        .OUT_uop      (out_uop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [170:0] act, input logic [170:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    DIV_DISP_UOP_T mq[$];
    int            cyc        = 0;
    int            last_issue = -1000;
    logic          m_infl_v   = 1'b0;
    logic [5:0]    m_infl_sqn = '0;
    logic          m_ready    = 1'b1;
    logic [170:0]  m_out      = '0;

    function automatic logic older(input logic [5:0] a, input logic [5:0] b);
        return $signed(6'(a - b)) < 0;
    endfunction

    function automatic logic younger(input logic [5:0] a, input logic [5:0] b);
        return $signed(6'(a - b)) > 0;
    endfunction

    function automatic DIV_DISP_UOP_T m_wake(input DIV_DISP_UOP_T u);
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i]) begin
                if (!u.availA && wb_tag[i*6 +: 6] == u.tagA) begin
                    u.availA = 1'b1;
                    u.srcA   = wb_result[i*32 +: 32];
                end
                if (!u.availB && wb_tag[i*6 +: 6] == u.tagB) begin
                    u.availB = 1'b1;
                    u.srcB   = wb_result[i*32 +: 32];
                end
            end
        end
        return u;
    endfunction

    function automatic logic [170:0] pack(input DIV_DISP_UOP_T u);
        logic [170:0] v;
        v          = '0;
        v[170:139] = u.srcA;
        v[138:107] = u.srcB;
        v[106:75]  = u.pc;
        v[42:37]   = u.opcode;
        v[36:31]   = u.tagDst;
        v[30:26]   = u.nmDst;
        v[25:20]   = u.sqN;
        v[0]       = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        int            best;
        logic          kill;
        logic [5:0]    bs;
        DIV_DISP_UOP_T tmp[$];
        if (rst) begin
            mq.delete();
            last_issue = -1000;
            m_infl_v   = 1'b0;
            m_ready    = 1'b1;
            m_out      = '0;
            cyc++;
            return;
        end
        kill  = branch[51];
        bs    = branch[18:13];
        m_out = '0;
        best  = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].availA && mq[i].availB && (best < 0 || older(mq[i].sqN, mq[best].sqN)))
                best = i;
        end
        if (!div_busy && (cyc - last_issue >= LAT) && !kill && best >= 0) begin
            m_out      = pack(mq[best]);
            last_issue = cyc;
            m_infl_v   = 1'b1;
            m_infl_sqn = mq[best].sqN;
            mq.delete(best);
        end
        if (kill) begin
            tmp = {};
            foreach (mq[i]) if (!younger(mq[i].sqN, bs)) tmp.push_back(mq[i]);
            mq = tmp;
            if (m_infl_v && younger(m_infl_sqn, bs)) begin
                m_infl_v   = 1'b0;
                last_issue = -1000;
            end
        end
        foreach (mq[i]) mq[i] = m_wake(mq[i]);
        if (enq_valid && m_ready && !(kill && younger(enq_uop.sqN, bs)))
            mq.push_back(m_wake(enq_uop));
        m_ready = (mq.size() < DEPTH);
        cyc++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("enq_ready", 171'(enq_ready), 171'(m_ready));
        check("out_valid", 171'(out_uop[0]), 171'(m_out[0]));
        if (m_out[0]) check("out_uop", out_uop, m_out);
    endtask

    task automatic idle();
        enq_valid = 1'b0;
        wb_valid  = '0;
        branch    = '0;
        div_busy  = 1'b0;
    endtask

    task automatic wait_idle();
        idle();
        repeat (LAT + 6) tick();
    endtask

    function automatic DIV_DISP_UOP_T mk(input logic [5:0] s, input logic [31:0] a,
                                         input logic [31:0] b, input logic av_a,
                                         input logic av_b, input logic [5:0] t_a,
                                         input logic [5:0] t_b, input logic [5:0] op);
        DIV_DISP_UOP_T u;
        u        = '0;
        u.sqN    = s;
        u.srcA   = a;
        u.srcB   = b;
        u.availA = av_a;
        u.availB = av_b;
        u.tagA   = t_a;
        u.tagB   = t_b;
        u.opcode = op;
        u.tagDst = s ^ 6'h2a;
        u.nmDst  = s[4:0];
        u.pc     = 32'h1000 + {24'd0, s, 2'b00};
        return u;
    endfunction

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (out_uop[0]) pulses++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [5:0]  sqn;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [5:0]  exp_op;
        logic [5:0]  exp_sqn;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int         pulses;
        int         gap;
        logic [5:0] sq;

        vecs[0] = '{32'd100,       32'd7,         OP_DIV,  6'd3,  32'd100,       32'd7,         OP_DIV,  6'd3};
        vecs[1] = '{32'hffff_ffff, 32'd1,         OP_DIVU, 6'd4,  32'hffff_ffff, 32'd1,         OP_DIVU, 6'd4};
        vecs[2] = '{32'd0,         32'd0,         OP_REM,  6'd5,  32'd0,         32'd0,         OP_REM,  6'd5};
        vecs[3] = '{32'h8000_0000, 32'hffff_ffff, OP_REMU, 6'd63, 32'h8000_0000, 32'hffff_ffff, OP_REMU, 6'd63};

        rst       = 1'b1;
        enq_uop   = '0;
        wb_tag    = '0;
        wb_result = '0;
        idle();
        tick();
        tick();
        check("reset_enq_ready", 171'(enq_ready), 171'(1));
        check("reset_out_valid", 171'(out_uop[0]), 171'(0));
        rst = 1'b0;

        // Ready uop, idle divider: issued two cycles after enqueue.
        foreach (vecs[k]) begin
            wait_idle();
            enq_valid = 1'b1;
            enq_uop   = mk(vecs[k].sqn, vecs[k].a, vecs[k].b, 1'b1, 1'b1, 6'd63, 6'd63, vecs[k].op);
            tick();
            idle();
            check("vec_t1_valid", 171'(out_uop[0]), 171'(0));
            tick();
            check("vec_t2_valid", 171'(out_uop[0]), 171'(1));
            check("vec_srcA", 171'(out_uop[170:139]), 171'(vecs[k].exp_a));
            check("vec_srcB", 171'(out_uop[138:107]), 171'(vecs[k].exp_b));
            check("vec_opcode", 171'(out_uop[42:37]), 171'(vecs[k].exp_op));
            check("vec_sqn", 171'(out_uop[25:20]), 171'(vecs[k].exp_sqn));
        end

        // Wakeup of tagA=5 three cycles after enqueue; bus 0 beats bus 2.
        wait_idle();
        enq_valid = 1'b1;
        enq_uop   = mk(6'd30, 32'hdead, 32'd3, 1'b0, 1'b1, 6'd5, 6'd63, OP_DIV);
        tick();
        idle();
        tick();
        tick();
        check("wake_before", 171'(out_uop[0]), 171'(0));
        wb_valid  = 3'b101;
        wb_tag    = {6'd5, 6'd9, 6'd5};
        wb_result = {32'hbad0_bad0, 32'd0, 32'h1234};
        tick();
        idle();
        check("wake_t1", 171'(out_uop[0]), 171'(0));
        tick();
        check("wake_t2_valid", 171'(out_uop[0]), 171'(1));
        check("wake_srcA", 171'(out_uop[170:139]), 171'(32'h1234));

        // Wrap-around age: 62 is older than 1; second issue exactly LAT later.
        wait_idle();
        div_busy  = 1'b1;
        enq_valid = 1'b1;
        enq_uop   = mk(6'd1, 32'd11, 32'd2, 1'b1, 1'b1, 6'd63, 6'd63, OP_DIV);
        tick();
        enq_uop   = mk(6'd62, 32'd22, 32'd2, 1'b1, 1'b1, 6'd63, 6'd63, OP_DIV);
        tick();
        idle();
        tick();
        check("age_first_valid", 171'(out_uop[0]), 171'(1));
        check("age_first_sqn", 171'(out_uop[25:20]), 171'(6'd62));
        gap = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            tick();
            if (out_uop[0]) begin
                gap = k;
                break;
            end
        end
        check("age_gap", 171'(gap), 171'(LAT));
        check("age_second_sqn", 171'(out_uop[25:20]), 171'(6'd1));

        // Full queue: ready drops, offered uop is dropped, one issue reopens a slot.
        wait_idle();
        div_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            enq_valid = 1'b1;
            enq_uop   = mk(6'(20 + k), 32'(k), 32'd5, 1'b1, 1'b1, 6'd63, 6'd63, OP_DIVU);
            tick();
        end
        check("full_ready", 171'(enq_ready), 171'(0));
        enq_uop = mk(6'd24, 32'd99, 32'd5, 1'b1, 1'b1, 6'd63, 6'd63, OP_DIVU);
        tick();
        check("full_ready_hold", 171'(enq_ready), 171'(0));
        idle();
        tick();
        check("full_issue_sqn", 171'(out_uop[25:20]), 171'(6'd20));
        check("full_ready_after", 171'(enq_ready), 171'(1));
        count_pulses(3 * LAT + 10, pulses);
        check("full_drain_count", 171'(pulses), 171'(3));

        // Mispredict kills 12, 14 and in-flight 16; 10 issues the next cycle.
        wait_idle();
        enq_valid = 1'b1;
        enq_uop   = mk(6'd16, 32'd160, 32'd4, 1'b1, 1'b1, 6'd63, 6'd63, OP_REM);
        tick();
        idle();
        tick();
        check("kill_inflight_sqn", 171'(out_uop[25:20]), 171'(6'd16));
        for (int k = 0; k < 3; k++) begin
            enq_valid = 1'b1;
            enq_uop   = mk(6'(10 + 2 * k), 32'(100 + k), 32'd4, 1'b1, 1'b1, 6'd63, 6'd63, OP_REM);
            tick();
        end
        enq_valid      = 1'b0;
        branch[51]     = 1'b1;
        branch[18:13]  = 6'd11;
        tick();
        idle();
        check("kill_cycle_valid", 171'(out_uop[0]), 171'(0));
        tick();
        check("kill_resume_valid", 171'(out_uop[0]), 171'(1));
        check("kill_resume_sqn", 171'(out_uop[25:20]), 171'(6'd10));
        count_pulses(LAT + 10, pulses);
        check("kill_no_more", 171'(pulses), 171'(0));

        // Reset mid-cooldown with three entries waiting.
        wait_idle();
        enq_valid = 1'b1;
        enq_uop   = mk(6'd40, 32'd400, 32'd9, 1'b1, 1'b1, 6'd63, 6'd63, OP_DIV);
        tick();
        idle();
        tick();
        check("rst_pre_issue", 171'(out_uop[0]), 171'(1));
        for (int k = 0; k < 3; k++) begin
            enq_valid = 1'b1;
            enq_uop   = mk(6'(41 + k), 32'(k), 32'd9, 1'b1, 1'b1, 6'd63, 6'd63, OP_DIV);
            tick();
        end
        enq_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_out_valid", 171'(out_uop[0]), 171'(0));
        check("rst_enq_ready", 171'(enq_ready), 171'(1));
        count_pulses(LAT + 10, pulses);
        check("rst_empty", 171'(pulses), 171'(0));

        // Randomized traffic against the model.
        sq = 6'd0;
        for (int n = 0; n < 3000; n++) begin
            enq_valid = ($urandom_range(0, 1) == 1);
            enq_uop   = mk(sq, $urandom, $urandom, 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                           6'($urandom_range(0, 7)), OP_DIV + 6'($urandom_range(0, 3)));
            if (enq_valid && m_ready) sq = sq + 6'd1;
            for (int i = 0; i < NUM_WB; i++) begin
                wb_valid[i]        = ($urandom_range(0, 9) < 4);
                wb_tag[i*6 +: 6]   = 6'($urandom_range(0, 7));
                wb_result[i*32 +: 32] = $urandom;
            end
            div_busy = ($urandom_range(0, 9) == 0);
            branch   = '0;
            if ($urandom_range(0, 29) == 0) begin
                branch[51]    = 1'b1;
                branch[18:13] = sq - 6'($urandom_range(1, 6));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
